// File: rtl/led_breathe_pwm.sv
// LED "breathing" driver: a prescaled PWM counter whose duty is ramped up, held,
// ramped down and held again by a small sequencing FSM while en is high.
module led_breathe_pwm #(
    parameter int PRESC        = 12000,
    parameter int PWM_BITS     = 8,
    parameter int STEP_PERIODS = 4,
    parameter int HOLD_PERIODS = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    output logic                led,
    output logic [PWM_BITS-1:0] level,
    output logic [2:0]          state,
    output logic                breath_done
);

    localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam int SW = $clog2(STEP_PERIODS + 1);
    localparam int HW = $clog2(HOLD_PERIODS + 1);

    localparam logic [PW-1:0]       PRESC_LAST    = PW'(PRESC - 1);
    localparam logic [SW-1:0]       STEP_LAST     = SW'(STEP_PERIODS - 1);
    localparam logic [HW-1:0]       HOLD_LAST     = HW'(HOLD_PERIODS - 1);
    localparam logic [PWM_BITS-1:0] LEVEL_MAX     = '1;
    localparam logic [PWM_BITS-1:0] LEVEL_PRE_MAX = LEVEL_MAX - 1'b1;
    localparam logic [PWM_BITS-1:0] LEVEL_ONE     = PWM_BITS'(1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        UP      = 3'd1,
        HOLD_HI = 3'd2,
        DOWN    = 3'd3,
        HOLD_LO = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic [PWM_BITS-1:0] pwm_q, pwm_d;
    logic [PWM_BITS-1:0] level_q, level_d;
    logic [SW-1:0]       step_q, step_d;
    logic [HW-1:0]       hold_q, hold_d;
    logic                led_q, led_d;
    logic                breath_done_q, breath_done_d;

    logic tick;
    logic period_end;

    assign tick       = (presc_q == PRESC_LAST);
    assign period_end = tick && (pwm_q == LEVEL_MAX);

    always_comb begin
        // NOTE: every _d gets a default up front so no path through the case leaves
        // a signal unassigned, which would otherwise infer a latch.
        presc_d       = tick ? '0 : presc_q + 1'b1;
        pwm_d         = tick ? pwm_q + 1'b1 : pwm_q;
        level_d       = level_q;
        step_d        = step_q;
        hold_d        = hold_q;
        state_d       = state_q;
        breath_done_d = 1'b0;
        led_d         = (state_q != IDLE) && en && (pwm_q < level_q);

        case (state_q)
            IDLE: begin
                presc_d = '0;
                pwm_d   = '0;
                level_d = '0;
                step_d  = '0;
                hold_d  = '0;
                if (en) state_d = UP;
            end
            UP: begin
                if (period_end) begin
                    if (step_q == STEP_LAST) begin
                        step_d = '0;
                        if (level_q != LEVEL_MAX) level_d = level_q + 1'b1;
                        if (level_q == LEVEL_PRE_MAX) state_d = HOLD_HI;
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
            end
            HOLD_HI: begin
                if (period_end) begin
                    if (hold_q == HOLD_LAST) begin
                        hold_d  = '0;
                        state_d = DOWN;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end
            DOWN: begin
                if (period_end) begin
                    if (step_q == STEP_LAST) begin
                        step_d = '0;
                        if (level_q != '0) level_d = level_q - 1'b1;
                        if (level_q == LEVEL_ONE) state_d = HOLD_LO;
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
            end
            HOLD_LO: begin
                if (period_end) begin
                    if (hold_q == HOLD_LAST) begin
                        hold_d        = '0;
                        state_d       = UP;
                        breath_done_d = 1'b1;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Dropping en wins over anything the sequencer wanted on this edge.
        if (state_q != IDLE && !en) begin
            state_d       = IDLE;
            presc_d       = '0;
            pwm_d         = '0;
            level_d       = '0;
            step_d        = '0;
            hold_d        = '0;
            breath_done_d = 1'b0;
        end
    end

    // NOTE: sequential state is updated only with non-blocking assignments so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            presc_q       <= '0;
            pwm_q         <= '0;
            level_q       <= '0;
            step_q        <= '0;
            hold_q        <= '0;
            led_q         <= 1'b0;
            breath_done_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            presc_q       <= presc_d;
            pwm_q         <= pwm_d;
            level_q       <= level_d;
            step_q        <= step_d;
            hold_q        <= hold_d;
            led_q         <= led_d;
            breath_done_q <= breath_done_d;
        end
    end

    assign led         = led_q;
    assign level       = level_q;
    assign state       = state_q;
    assign breath_done = breath_done_q;

endmodule

// File: tb/tb_led_breathe_pwm.sv
// Self-checking bench for led_breathe_pwm: directed timing scenarios plus random
// en/rst activity, all compared against a closed-form model of the breath cycle.
module tb_led_breathe_pwm;

    localparam int PRESC    = 2;
    localparam int PWM_BITS = 3;
    localparam int STEP     = 1;
    localparam int HOLD     = 2;
    localparam int MAXV     = (1 << PWM_BITS) - 1;
    localparam int PER      = PRESC << PWM_BITS;
    localparam int BREATH   = 2 * MAXV * STEP + 2 * HOLD;

    logic                clk = 1'b0;
    logic                rst;
    logic                en;
    logic                led;
    logic [PWM_BITS-1:0] level;
    logic [2:0]          state;
    logic                breath_done;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: run = sequencer active, k = edges since the enabling edge E0.
    bit run      = 1'b0;
    int k        = 0;
    bit prev_run = 1'b0;
    int prev_k   = 0;

    led_breathe_pwm #(
        .PRESC       (PRESC),
        .PWM_BITS    (PWM_BITS),
        .STEP_PERIODS(STEP),
        .HOLD_PERIODS(HOLD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .led        (led),
        .level      (level),
        .state      (state),
        .breath_done(breath_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Position in the breath follows from the number of completed PWM periods.
    function automatic void ref_at(input int kk, output int st, output int lv, output int pw);
        int n;
        int m;
        n  = kk / PER;
        m  = n % BREATH;
        pw = (kk % PER) / PRESC;
        if (m < MAXV * STEP) begin
            st = 1; lv = m / STEP;
        end else if (m < MAXV * STEP + HOLD) begin
            st = 2; lv = MAXV;
        end else if (m < 2 * MAXV * STEP + HOLD) begin
            st = 3; lv = MAXV - (m - MAXV * STEP - HOLD) / STEP;
        end else begin
            st = 4; lv = 0;
        end
    endfunction

    task automatic model_edge();
        prev_run = run;
        prev_k   = k;
        if (rst) run = 1'b0;
        else if (!run) begin
            if (en) begin run = 1'b1; k = 0; end
        end else if (!en) run = 1'b0;
        else k++;
    endtask

    task automatic compare_all();
        int es, el, ep, ps, pl, pp, eled, ebd;
        if (!run) begin
            es = 0; el = 0; eled = 0; ebd = 0;
        end else begin
            ref_at(k, es, el, ep);
            ebd = (k > 0 && k % PER == 0 && (k / PER) % BREATH == 0) ? 1 : 0;
            eled = 0;
            if (prev_run) begin
                ref_at(prev_k, ps, pl, pp);
                eled = (pp < pl) ? 1 : 0;
            end
        end
        check("state", state, es);
        check("level", level, el);
        check("led", led, eled);
        check("breath_done", breath_done, ebd);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int highs[0:39];
        int bd_cnt, bd_first, bd_second, st, lv, pw;
        bit found;

        foreach (highs[i]) highs[i] = 0;
        rst = 1'b1;
        en  = 1'b1;

        // Reset held with en high: everything stays cleared.
        repeat (3) begin
            @(negedge clk);
            check("rst_state", state, 0);
            check("rst_level", level, 0);
            check("rst_led", led, 0);
            check("rst_bd", breath_done, 0);
        end
        rst = 1'b0;
        cycle();
        check("rst_release_up", state, 1);

        // Two full breaths: ramp timing, duty per period and breath_done spacing.
        bd_cnt = 0; bd_first = -1; bd_second = -1;
        repeat (590) begin
            cycle();
            if (run && k >= 1 && (k - 1) / PER < 40) highs[(k - 1) / PER] += int'(led);
            if (breath_done) begin
                if (bd_cnt == 0) bd_first = k;
                else if (bd_cnt == 1) bd_second = k;
                bd_cnt++;
            end
            if (k == 16)  check("lvl_e16", level, 1);
            if (k == 112) check("hold_hi_e112", state, 2);
            if (k == 144) check("down_e144", state, 3);
            if (k == 256) check("hold_lo_e256", state, 4);
            if (k == 288) check("up_e288", state, 1);
        end
        check("duty_lvl0", highs[0], 0);
        check("duty_lvl3", highs[3], 6);
        check("duty_lvl7", highs[7], 14);
        check("bd_count", bd_cnt, 2);
        check("bd_first", bd_first, 288);
        check("bd_spacing", bd_second - bd_first, 288);

        // Enable drop while ramping at level 4.
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (run) begin
                ref_at(k, st, lv, pw);
                if (st == 1 && lv == 4) begin found = 1'b1; break; end
            end
            cycle();
        end
        check("find_up_lvl4", found, 1);
        check("pre_drop_level", level, 4);
        en = 1'b0;
        cycle();
        check("drop_state", state, 0);
        check("drop_level", level, 0);
        check("drop_led", led, 0);
        repeat (3) cycle();
        en = 1'b1;
        cycle();
        repeat (16) cycle();
        check("reen_level", level, 1);

        // Async reset in the middle of HOLD_HI.
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (run) begin
                ref_at(k, st, lv, pw);
                if (st == 2 && (k % PER) == PER / 2) begin found = 1'b1; break; end
            end
            cycle();
        end
        check("find_hold_hi", found, 1);
        #2 rst = 1'b1;
        run = 1'b0;
        #1;
        check("async_state", state, 0);
        check("async_level", level, 0);
        check("async_led", led, 0);
        check("async_bd", breath_done, 0);
        repeat (2) cycle();
        rst = 1'b0;
        cycle();
        check("resume_up", state, 1);
        repeat (112) cycle();
        check("resume_hold_hi", state, 2);
        check("resume_level", level, 7);

        // Random en toggles and async reset pulses.
        repeat (3000) begin
            if ($urandom_range(0, 199) == 0) begin
                #2 rst = 1'b1;
                run = 1'b0;
                #2 rst = 1'b0;
            end
            if (run) begin
                if ($urandom_range(0, 599) == 0) en = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                en = 1'b1;
            end else if ($urandom_range(0, 3) == 0) begin
                en = 1'b0;
            end
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
